// File: rtl/sched_pkg.sv
// Shared types and matrix helpers for lru_matrix_scheduler.
// The matrix cell helpers are defined per cell, so every scheduler width can use
// them without a fixed maximum matrix size.
package sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Reset priority: row i beats every higher-numbered column, so requester 0 starts highest.
  function automatic logic reset_cell(input int i, input int j);
    return (j > i);
  endfunction

  // Release update for winner g: row g is cleared and column g is set (off the diagonal).
  // The winner therefore loses to everyone, and every other pairing is unchanged.
  function automatic logic release_cell(input logic cur, input int i, input int j, input int g);
    if (i == g) begin
      return 1'b0;
    end else if (j == g) begin
      return 1'b1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/lru_pick.sv
// Combinational winner select from a least-recently-granted priority matrix.
// Requester i wins when it is requesting and it beats every other active requester.
module lru_pick
  import sched_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0][N-1:0]   mat_i,
  input  logic [N-1:0]          req_i,
  output logic [N-1:0]          win_o,
  output logic [$clog2(N)-1:0]  idx_o
);

  localparam int IW = $clog2(N);

  // The matrix invariants make win_o one-hot whenever req_i is non-zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    win_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      win_o[i] = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req_i[j] && !mat_i[i][j]) begin
          win_o[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (win_o[i]) begin
        idx_o = idx_o | IW'(i);
      end
    end
  end

endmodule

// File: rtl/lru_matrix_scheduler.sv
// Least-recently-granted scheduler: arbitrates with a priority matrix, holds the
// grant for the whole transaction, and demotes the winner when it releases.
// Optional feature: define SCHED_TIMEOUT_EN to bound grants to TIMEOUT cycles.
module lru_matrix_scheduler
  import sched_pkg::*;
#(
  parameter int N       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          last,
  output logic [N-1:0]          gnt,
  output logic                  valid_gnt,
  output logic [$clog2(N)-1:0]  gnt_id,
  output logic                  timeout
);

  localparam int IW = $clog2(N);

  state_e                 state_q, state_d;
  logic [N-1:0]           gnt_q, gnt_d;
  logic [IW-1:0]          gnt_id_q, gnt_id_d;
  logic [N-1:0][N-1:0]    mat_q, mat_d;
  logic [N-1:0][N-1:0]    mat_rst, mat_rel;
  logic [N-1:0]           win;
  logic [IW-1:0]          win_idx;
  logic                   nat_rel;
  logic                   force_rel;

  lru_pick #(.N(N)) u_pick (
    .mat_i (mat_q),
    .req_i (req),
    .win_o (win),
    .idx_o (win_idx)
  );

  // Reset pattern and post-release pattern for the current matrix and granted index.
  always_comb begin
    mat_rst = '0;
    mat_rel = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mat_rst[i][j] = reset_cell(i, j);
        mat_rel[i][j] = release_cell(mat_q[i][j], i, j, int'(gnt_id_q));
      end
    end
  end

  // A granted transaction ends on its last beat or when its request drops.
  assign nat_rel = |(gnt_q & last) || !(|(gnt_q & req));

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;

  assign force_rel = (state_q == GRANT) && (hold_cnt_q == CW'(TIMEOUT - 1));

  // Hold counter: zero on grant entry, counts GRANT cycles; pulse only when no natural release.
  always_comb begin
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
    if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      timeout_d  = force_rel && !nat_rel;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold in GRANT, demote the winner on release.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    mat_d    = mat_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d    = win;
          gnt_id_d = win_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (nat_rel || force_rel) begin
          gnt_d   = '0;
          mat_d   = mat_rel;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and matrix registers; reset restores the initial priority order.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      mat_q    <= mat_rst;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      mat_q    <= mat_d;
    end
  end

  assign gnt       = gnt_q;
  assign valid_gnt = (state_q == GRANT);
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_lru_matrix_scheduler.sv
// Scoreboard bench for lru_matrix_scheduler (N=3, TIMEOUT=16).
// Stimulus pushes the expected grant for each arbitration; a monitor pops it on
// every rising edge of valid_gnt. Matrix state is compared against hand-derived rows.
module tb_lru_matrix_scheduler;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic [N-1:0] gnt;
  logic         valid_gnt;
  logic [1:0]   gnt_id;
  logic         timeout;

  typedef struct packed {
    logic [N-1:0] g;
    logic [1:0]   id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  lru_matrix_scheduler #(.N(N), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .gnt       (gnt),
    .valid_gnt (valid_gnt),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rows are given as row 0, row 1, row 2; bit j of a row is column j.
  task automatic chk_mat(input string name, input logic [2:0] r0, input logic [2:0] r1,
                         input logic [2:0] r2);
    check(name, 32'(dut.mat_q), 32'({r2, r1, r0}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [N-1:0] g, input logic [1:0] id);
    exp_t e;
    e.g  = g;
    e.id = id;
    exp_q.push_back(e);
  endtask

  // Monitor: each new grant must match the oldest expected grant.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_gnt && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected grant", 32'(gnt), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("grant vector", 32'(gnt), 32'(e.g));
          check("grant id", 32'(gnt_id), 32'(e.id));
        end
      end
      prev_v = valid_gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    last = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset gnt", 32'(gnt), 32'(0));
    check("reset valid", 32'(valid_gnt), 32'(0));
    check("reset id", 32'(gnt_id), 32'(0));
    check("reset timeout", 32'(timeout), 32'(0));
    chk_mat("reset matrix", 3'b110, 3'b100, 3'b000);

    // Requesters 1 and 2: 1 wins, holds 5 cycles, releases with last.
    expect_grant(3'b010, 2'd1);
    req = 3'b110;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("hold gnt 1", 32'(gnt), 32'(3'b010));
      tick();
    end
    last = 3'b010;
    tick();
    last = '0;
    req  = '0;
    check("release 1 gnt", 32'(gnt), 32'(0));
    check("release 1 valid", 32'(valid_gnt), 32'(0));
    check("id holds after release", 32'(gnt_id), 32'(1));
    chk_mat("matrix after g1", 3'b110, 3'b000, 3'b010);

    // Same request pattern: requester 1 is now lowest, so 2 wins.
    expect_grant(3'b100, 2'd2);
    req = 3'b110;
    tick();
    check("hold gnt 2", 32'(gnt), 32'(3'b100));
    last = 3'b100;
    tick();
    last = '0;
    req  = '0;
    chk_mat("matrix after g2", 3'b110, 3'b100, 3'b000);

    // All three requesting: order 0,1,2 with exactly one IDLE cycle between grants.
    expect_grant(3'b001, 2'd0);
    expect_grant(3'b010, 2'd1);
    expect_grant(3'b100, 2'd2);
    req = 3'b111;
    for (int g = 0; g < 3; g++) begin
      tick();
      check("rr granted", 32'(valid_gnt), 32'(1));
      last = 3'(1 << g);
      tick();
      last = '0;
      if (g == 2) req = '0;
      check("rr idle gap", 32'(valid_gnt), 32'(0));
    end
    chk_mat("matrix after rr", 3'b110, 3'b100, 3'b000);

    // Non-granted activity is ignored; dropping req[0] aborts with an update.
    expect_grant(3'b001, 2'd0);
    req = 3'b001;
    tick();
    req = 3'b101;
    tick();
    check("ignore req2 up", 32'(gnt), 32'(3'b001));
    req = 3'b001;
    tick();
    check("ignore req2 down", 32'(gnt), 32'(3'b001));
    req  = 3'b101;
    last = 3'b100;
    tick();
    last = '0;
    check("ignore last2", 32'(gnt), 32'(3'b001));
    req = 3'b000;
    tick();
    check("abort gnt", 32'(gnt), 32'(0));
    chk_mat("matrix after abort", 3'b000, 3'b101, 3'b001);

    expect_grant(3'b010, 2'd1);
    req = 3'b011;
    tick();
    last = 3'b010;
    tick();
    last = '0;
    req  = '0;
    chk_mat("matrix after g1 again", 3'b010, 3'b000, 3'b011);

    // Reset during a grant: outputs and matrix return to reset values.
    expect_grant(3'b100, 2'd2);
    req = 3'b111;
    tick();
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    check("midgrant rst gnt", 32'(gnt), 32'(0));
    check("midgrant rst valid", 32'(valid_gnt), 32'(0));
    check("midgrant rst id", 32'(gnt_id), 32'(0));
    check("midgrant rst timeout", 32'(timeout), 32'(0));
    chk_mat("midgrant rst matrix", 3'b110, 3'b100, 3'b000);
    rst = 1'b0;
    tick();

`ifdef SCHED_TIMEOUT_EN
    // Held request with no last: forced release after 16 GRANT cycles.
    expect_grant(3'b001, 2'd0);
    req = 3'b001;
    tick();
    for (int k = 0; k < 16; k++) begin
      check("timeout hold gnt", 32'(gnt), 32'(3'b001));
      check("timeout not yet", 32'(timeout), 32'(0));
      tick();
    end
    check("forced release gnt", 32'(gnt), 32'(0));
    check("timeout pulse", 32'(timeout), 32'(1));
    chk_mat("matrix after timeout", 3'b000, 3'b101, 3'b001);
    expect_grant(3'b010, 2'd1);
    req = 3'b011;
    tick();
    check("timeout pulse ends", 32'(timeout), 32'(0));
    check("post-timeout gnt", 32'(gnt), 32'(3'b010));
    last = 3'b010;
    tick();
    last = '0;
    req  = '0;
`else
    // Without the timeout feature a grant is unbounded.
    expect_grant(3'b001, 2'd0);
    req = 3'b001;
    tick();
    repeat (20) tick();
    check("unbounded gnt", 32'(gnt), 32'(3'b001));
    check("timeout tied low", 32'(timeout), 32'(0));
    last = 3'b001;
    tick();
    last = '0;
    req  = '0;
    check("unbounded release", 32'(gnt), 32'(0));
`endif

    tick();
    tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
